// File: rtl/mem_write_checker.sv
// mem_write_checker
//   Regression sequencer for a CPU under test. It steps through NUM_TESTS
//   programs. For each program it drives test_sel and holds cpu_reset high for
//   RESET_CYCLES cycles. It then watches the data-memory write bus for WINDOW
//   cycles. A test passes when the expected (address, data) store appears in
//   its window. With STRICT set, the test also needs no stray store.
// Ports
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             one-cycle request to begin a full run (ignored while busy)
//   memwrite/dataadr/writedata   CPU data-memory write bus
//   exp_addr/exp_data packed expected store per test, test i at [i*W +: W]
//   test_sel          program select for the current test
//   cpu_reset         active-high reset to the CPU under test
//   busy/done         run in progress / run finished with results valid
//   pass_vec, pass_count          per-test pass bits and number passed
//   mismatch_count    non-matching stores over the run, saturating
//   match_cycle       window cycle of the first match of the last matching test
module mem_write_checker #(
  parameter int NUM_TESTS    = 6,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int RESET_CYCLES = 2,
  parameter int WINDOW       = 199,
  parameter int STRICT       = 0,
  localparam int SEL_W = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  localparam int CNT_W = $clog2(NUM_TESTS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        memwrite,
  input  logic [ADDR_W-1:0]           dataadr,
  input  logic [DATA_W-1:0]           writedata,
  input  logic [NUM_TESTS*ADDR_W-1:0] exp_addr,
  input  logic [NUM_TESTS*DATA_W-1:0] exp_data,
  output logic [SEL_W-1:0]            test_sel,
  output logic                        cpu_reset,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_TESTS-1:0]        pass_vec,
  output logic [CNT_W-1:0]            pass_count,
  output logic [15:0]                 mismatch_count,
  output logic [31:0]                 match_cycle
);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_RUN, S_EVAL, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     test_sel_q, test_sel_d;
  logic [31:0]          rst_cnt_q, rst_cnt_d;
  logic [31:0]          win_cnt_q, win_cnt_d;
  logic                 hit_q, hit_d;
  logic                 bad_q, bad_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_TESTS-1:0] pass_vec_q, pass_vec_d;
  logic [CNT_W-1:0]     pass_count_q, pass_count_d;
  logic [15:0]          mm_cnt_q, mm_cnt_d;
  logic [31:0]          match_cycle_q, match_cycle_d;

  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic                 match;
  logic                 pass;

  // Expected store for the current test.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      if (test_sel_q == SEL_W'(i)) begin
        sel_addr = exp_addr[i*ADDR_W +: ADDR_W];
        sel_data = exp_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign match = memwrite && (dataadr == sel_addr) && (writedata == sel_data);
  assign pass  = hit_q && ((STRICT == 0) || !bad_q);

  always_comb begin
    state_d       = state_q;
    test_sel_d    = test_sel_q;
    rst_cnt_d     = rst_cnt_q;
    win_cnt_d     = win_cnt_q;
    hit_d         = hit_q;
    bad_d         = bad_q;
    pass_vec_d    = pass_vec_q;
    pass_count_d  = pass_count_q;
    mm_cnt_d      = mm_cnt_q;
    match_cycle_d = match_cycle_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RST;
          rst_cnt_d     = '0;
          test_sel_d    = '0;
          pass_vec_d    = '0;
          pass_count_d  = '0;
          mm_cnt_d      = '0;
          match_cycle_d = '0;
        end
      end
      S_RST: begin
        hit_d = 1'b0;
        bad_d = 1'b0;
        if (rst_cnt_q == 32'(RESET_CYCLES - 1)) begin
          state_d   = S_RUN;
          win_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (memwrite) begin
          if (match) begin
            // Only the first match in a window records its cycle.
            if (!hit_q) begin
              hit_d         = 1'b1;
              match_cycle_d = win_cnt_q;
            end
          end else begin
            bad_d = 1'b1;
            if (mm_cnt_q != '1) mm_cnt_d = mm_cnt_q + 16'd1;
          end
        end
        if (win_cnt_q == 32'(WINDOW - 1)) state_d = S_EVAL;
        else                              win_cnt_d = win_cnt_q + 32'd1;
      end
      S_EVAL: begin
        for (int unsigned i = 0; i < NUM_TESTS; i++) begin
          if (test_sel_q == SEL_W'(i)) pass_vec_d[i] = pass;
        end
        pass_count_d = pass_count_q + CNT_W'(pass);
        if (test_sel_q == SEL_W'(NUM_TESTS - 1)) begin
          state_d = S_DONE;
        end else begin
          test_sel_d = test_sel_q + 1'b1;
          rst_cnt_d  = '0;
          state_d    = S_RST;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the next state, so they line up with it when registered.
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = (state_d == S_RST) || (state_d == S_RUN) || (state_d == S_EVAL);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      test_sel_q    <= '0;
      rst_cnt_q     <= '0;
      win_cnt_q     <= '0;
      hit_q         <= 1'b0;
      bad_q         <= 1'b0;
      cpu_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_vec_q    <= '0;
      pass_count_q  <= '0;
      mm_cnt_q      <= '0;
      match_cycle_q <= '0;
    end else begin
      state_q       <= state_d;
      test_sel_q    <= test_sel_d;
      rst_cnt_q     <= rst_cnt_d;
      win_cnt_q     <= win_cnt_d;
      hit_q         <= hit_d;
      bad_q         <= bad_d;
      cpu_reset_q   <= cpu_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_vec_q    <= pass_vec_d;
      pass_count_q  <= pass_count_d;
      mm_cnt_q      <= mm_cnt_d;
      match_cycle_q <= match_cycle_d;
    end
  end

  assign test_sel       = test_sel_q;
  assign cpu_reset      = cpu_reset_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass_vec       = pass_vec_q;
  assign pass_count     = pass_count_q;
  assign mismatch_count = mm_cnt_q;
  assign match_cycle    = match_cycle_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker. Two instances share one CPU bus:
// dut is lenient and dut_s is strict. Each test's expected outcome is modelled
// when its stores are planned. That outcome is queued and then checked after
// the test's evaluation cycle.
module tb_mem_write_checker;

  localparam int NT = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RC = 2;
  localparam int WN = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            memwrite;
  logic [AW-1:0]   dataadr;
  logic [DW-1:0]   writedata;
  logic [NT*AW-1:0] exp_addr;
  logic [NT*DW-1:0] exp_data;

  logic [1:0]  test_sel,   test_sel_s;
  logic        cpu_reset,  cpu_reset_s;
  logic        busy,       busy_s;
  logic        done,       done_s;
  logic [NT-1:0] pass_vec, pass_vec_s;
  logic [2:0]  pass_count, pass_count_s;
  logic [15:0] mismatch_count, mismatch_count_s;
  logic [31:0] match_cycle, match_cycle_s;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_write_checker #(.NUM_TESTS(NT), .ADDR_W(AW), .DATA_W(DW), .RESET_CYCLES(RC),
                      .WINDOW(WN), .STRICT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data),
    .test_sel(test_sel), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .pass_vec(pass_vec), .pass_count(pass_count), .mismatch_count(mismatch_count),
    .match_cycle(match_cycle));

  mem_write_checker #(.NUM_TESTS(NT), .ADDR_W(AW), .DATA_W(DW), .RESET_CYCLES(RC),
                      .WINDOW(WN), .STRICT(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data),
    .test_sel(test_sel_s), .cpu_reset(cpu_reset_s), .busy(busy_s), .done(done_s),
    .pass_vec(pass_vec_s), .pass_count(pass_count_s), .mismatch_count(mismatch_count_s),
    .match_cycle(match_cycle_s));

  typedef struct {
    int idx;
    bit lax;
    bit strict;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] ea [NT];
  logic [DW-1:0] ed [NT];

  // Stores planned for the next test: window cycle, address, data.
  int            st_n;
  int            st_c [4];
  logic [AW-1:0] st_a [4];
  logic [DW-1:0] st_d [4];

  // Model state for the current run.
  int          pc_exp, pcs_exp;
  logic [15:0] mm_exp;
  logic [31:0] mc_exp;
  logic [NT-1:0] pv_exp, pvs_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_st(input int k, input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_c[k] = c;
    st_a[k] = a;
    st_d[k] = d;
  endtask

  task automatic new_run();
    pc_exp  = 0;
    pcs_exp = 0;
    mm_exp  = '0;
    mc_exp  = '0;
    pv_exp  = '0;
    pvs_exp = '0;
  endtask

  // noise: drive a non-matching store while the CPU is held in reset.
  // start_c / abort_c: window cycle at which to pulse start or drop reset (-1 = never).
  task automatic run_test(input int idx, input bit noise, input int start_c, input int abort_c);
    bit   hit = 0;
    bit   bad = 0;
    int   waited = 0;
    exp_t e;
    for (int k = 0; k < st_n; k++) begin
      if (st_c[k] < WN) begin
        if (st_a[k] == ea[idx] && st_d[k] == ed[idx]) begin
          if (!hit) begin
            hit    = 1;
            mc_exp = 32'(st_c[k]);
          end
        end else begin
          bad = 1;
          if (mm_exp != 16'hFFFF) mm_exp = mm_exp + 16'd1;
        end
      end
    end
    sb.push_back('{idx: idx, lax: hit, strict: hit && !bad});

    while (cpu_reset !== 1'b0 && waited < 50) begin
      memwrite  = noise;
      dataadr   = ~ea[idx];
      writedata = '0;
      @(negedge clk);
      waited++;
    end
    chk($sformatf("run_wait_t%0d", idx), 64'(waited < 50), 64'd1);
    chk($sformatf("test_sel_t%0d", idx), 64'(test_sel), 64'(idx));
    chk($sformatf("test_sel_s_t%0d", idx), 64'(test_sel_s), 64'(idx));

    for (int c = 0; c <= WN; c++) begin
      memwrite  = 1'b0;
      dataadr   = '0;
      writedata = '0;
      start     = (c == start_c);
      for (int k = 0; k < st_n; k++) begin
        if (st_c[k] == c) begin
          memwrite  = 1'b1;
          dataadr   = st_a[k];
          writedata = st_d[k];
        end
      end
      if (c == abort_c) begin
        chk("pre_abort_pass_count", 64'(pass_count), 64'(pc_exp));
        chk("pre_abort_mismatch", 64'(mismatch_count), 64'(mm_exp));
        reset    = 1'b0;
        memwrite = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_test_sel", 64'(test_sel), 64'd0);
        chk("abort_pass_count", 64'(pass_count), 64'd0);
        chk("abort_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("abort_mismatch", 64'(mismatch_count), 64'd0);
        chk("abort_pass_vec", 64'(pass_vec), 64'd0);
        chk("abort_match_cycle", 64'(match_cycle), 64'd0);
        sb.delete();
        return;
      end
      @(negedge clk);
    end
    memwrite = 1'b0;
    start    = 1'b0;

    e = sb.pop_front();
    pv_exp[e.idx]  = e.lax;
    pvs_exp[e.idx] = e.strict;
    pc_exp  += int'(e.lax);
    pcs_exp += int'(e.strict);
    chk($sformatf("pass_t%0d", e.idx), 64'(pass_vec[e.idx]), 64'(e.lax));
    chk($sformatf("pass_s_t%0d", e.idx), 64'(pass_vec_s[e.idx]), 64'(e.strict));
    chk($sformatf("pass_count_t%0d", e.idx), 64'(pass_count), 64'(pc_exp));
    chk($sformatf("pass_count_s_t%0d", e.idx), 64'(pass_count_s), 64'(pcs_exp));
    chk($sformatf("mismatch_t%0d", e.idx), 64'(mismatch_count), 64'(mm_exp));
    chk($sformatf("mismatch_s_t%0d", e.idx), 64'(mismatch_count_s), 64'(mm_exp));
    chk($sformatf("match_cycle_t%0d", e.idx), 64'(match_cycle), 64'(mc_exp));
  endtask

  initial begin
    int cyc_start;
    reset     = 1'b0;
    start     = 1'b0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    ea[0] = 32'h12;       ed[0] = 32'd21;
    ea[1] = 32'h100;      ed[1] = 32'hDEAD_BEEF;
    ea[2] = 32'h54;       ed[2] = 32'd7;
    ea[3] = 32'hFFFF_FFFC; ed[3] = 32'h8000_0001;
    for (int i = 0; i < NT; i++) begin
      exp_addr[i*AW +: AW] = ea[i];
      exp_data[i*DW +: DW] = ed[i];
    end

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_test_sel", 64'(test_sel), 64'd0);
    chk("rst_pass_vec", 64'(pass_vec), 64'd0);
    chk("rst_pass_count", 64'(pass_count), 64'd0);
    chk("rst_mismatch", 64'(mismatch_count), 64'd0);
    chk("rst_match_cycle", 64'(match_cycle), 64'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_cpu_reset", 64'(cpu_reset), 64'd1);

    // Run 1: full run to DONE.
    new_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc_start = cyc;
    chk("r1_busy", 64'(busy), 64'd1);
    chk("r1_cpu_reset", 64'(cpu_reset), 64'd1);

    st_n = 1; set_st(0, 7, ea[0], ed[0]);
    run_test(0, 0, -1, -1);
    st_n = 2; set_st(0, 3, ea[1], ed[1] + 32'd1); set_st(1, WN, ea[1], ed[1]);
    run_test(1, 0, -1, -1);
    st_n = 3; set_st(0, 2, ea[2], 32'd6); set_st(1, 5, ea[2], ed[2]); set_st(2, 9, ea[2], ed[2]);
    run_test(2, 0, -1, -1);
    st_n = 1; set_st(0, WN - 1, ea[3], ed[3]);
    run_test(3, 1, -1, -1);

    chk("r1_done", 64'(done), 64'd1);
    chk("r1_done_busy", 64'(busy), 64'd0);
    chk("r1_done_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("r1_run_cycles", 64'(cyc - cyc_start), 64'(NT * (RC + WN + 1)));
    chk("r1_pass_vec", 64'(pass_vec), 64'(pv_exp));
    chk("r1_pass_vec_s", 64'(pass_vec_s), 64'(pvs_exp));
    repeat (3) @(negedge clk);
    chk("r1_hold_pass_count", 64'(pass_count), 64'(pc_exp));
    chk("r1_hold_done", 64'(done), 64'd1);

    // Run 2: restart from DONE; start while busy; reset mid-run.
    new_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("r2_done_clr", 64'(done), 64'd0);
    chk("r2_busy", 64'(busy), 64'd1);
    chk("r2_pass_vec_clr", 64'(pass_vec), 64'd0);
    chk("r2_pass_count_clr", 64'(pass_count), 64'd0);
    chk("r2_mismatch_clr", 64'(mismatch_count), 64'd0);
    chk("r2_match_cycle_clr", 64'(match_cycle), 64'd0);
    chk("r2_test_sel_clr", 64'(test_sel), 64'd0);

    st_n = 1; set_st(0, 4, ea[0], 32'd0);
    run_test(0, 0, 6, -1);
    st_n = 1; set_st(0, 0, ea[1], ed[1]);
    run_test(1, 0, -1, -1);
    st_n = 0;
    run_test(2, 0, -1, -1);
    run_test(3, 0, -1, 5);

    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort_busy", 64'(busy), 64'd0);
    chk("post_abort_done", 64'(done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

endmodule
